// File: rtl/uart_frame_sender.sv
// Serialises a NUM_BYTES-wide payload as back-to-back 8N1 UART bytes, byte 0 first, LSB first.
// Outputs are registered; send_done pulses in the first idle cycle after the last stop bit.
module uart_frame_sender #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   send_done,
    output logic                   busy,
    output logic                   tx
);

    localparam int FRAME_W = 8 * NUM_BYTES;
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bit;
    logic [BYTE_W-1:0]    r_byte;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_send_q;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_state_nx;
    logic [BAUD_W-1:0]    w_baud_nx;
    logic [2:0]           w_bit_nx;
    logic [BYTE_W-1:0]    w_byte_nx;
    logic [FRAME_W-1:0]   w_frame_nx;
    logic                 w_tx_nx;
    logic                 w_busy_nx;
    logic                 w_done_nx;
    logic                 w_start;
    logic                 w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_frame  <= '0;
            r_send_q <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_baud   <= w_baud_nx;
            r_bit    <= w_bit_nx;
            r_byte   <= w_byte_nx;
            r_frame  <= w_frame_nx;
            r_send_q <= send;
            r_tx     <= w_tx_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    always_comb begin
        w_start    = send & ~r_send_q;
        w_bit_end  = (r_baud == BAUD_LAST);
        w_state_nx = r_state;
        w_baud_nx  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        w_frame_nx = r_frame;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                if (w_start) begin
                    w_state_nx = S_START;
                    w_frame_nx = data;
                    w_busy_nx  = 1'b1;
                    w_byte_nx  = '0;
                    w_bit_nx   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_bit_nx   = '0;
                end
            end
            S_DATA: begin
                // Frame is a shift register: the next bit to send is always at [0].
                if (w_bit_end) begin
                    w_frame_nx = {1'b0, r_frame[FRAME_W-1:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_bit_nx   = '0;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte == BYTE_LAST) begin
                        w_state_nx = S_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_START;
                        w_byte_nx  = r_byte + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // tx is derived from the next state so the line changes on the same edge as the FSM.
        case (w_state_nx)
            S_START: w_tx_nx = 1'b0;
            S_DATA:  w_tx_nx = w_frame_nx[0];
            default: w_tx_nx = 1'b1;
        endcase
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign send_done = r_done;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender with CLKS_PER_BIT=4, NUM_BYTES=40.
// Inputs driven and outputs sampled right after the falling edge.
module tb_uart_frame_sender;

    localparam int CPB = 4;
    localparam int NB  = 40;
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic            clk = 1'b0;
    logic            rst;
    logic            send;
    logic [8*NB-1:0] data;
    logic            send_done;
    logic            busy;
    logic            tx;

    int n_checks = 0;
    int n_errors = 0;

    uart_frame_sender #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .data      (data),
        .send_done (send_done),
        .busy      (busy),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [8*NB-1:0] obs, input logic [8*NB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] pat(input int mul, input int add);
        logic [8*NB-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'((k * mul + add) & 255);
        return p;
    endfunction

    // Called at cycle 0 of a frame (first tx-low cycle). mode 1: extra send pulse and
    // data change at act_cyc. mode 2: send low at the last stop cycle, high again in the
    // send_done cycle so the next frame (act_data) starts back to back.
    task automatic run_frame(input string tag, input logic [8*NB-1:0] exp, input int mode,
                             input int act_cyc, input logic [8*NB-1:0] act_data);
        logic [7:0] rx [NB];
        int werr, berr;
        logic exp_tx;
        werr = 0;
        berr = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            int p, j, k;
            p = c / CPB;
            k = p / 10;
            j = p % 10;
            if (j == 0)      exp_tx = 1'b0;
            else if (j == 9) exp_tx = 1'b1;
            else             exp_tx = exp[8*k + j - 1];
            if (tx !== exp_tx) werr++;
            if (c % CPB == CPB / 2 && j >= 1 && j <= 8) rx[k][j-1] = tx;
            if (busy !== 1'b1 || send_done !== 1'b0) berr++;
            if (mode == 1 && c == act_cyc) begin send = 1'b1; data = act_data; end
            if (mode == 1 && c == act_cyc + 1) send = 1'b0;
            if (mode == 2 && c == FRAME_CYC - 1) begin send = 1'b0; data = act_data; end
            step();
        end
        check({tag, " waveform"}, werr, 0);
        check({tag, " busy/done during frame"}, berr, 0);
        for (int k = 0; k < NB; k++)
            check($sformatf("%s byte%0d", tag, k), rx[k], exp[8*k +: 8]);
        check({tag, " send_done at end"}, send_done, 1'b1);
        check({tag, " busy at end"}, busy, 1'b0);
        check({tag, " tx at end"}, tx, 1'b1);
        if (mode == 2) begin
            send = 1'b1;
            step();
            check({tag, " back-to-back tx"}, tx, 1'b0);
            check({tag, " back-to-back busy"}, busy, 1'b1);
        end else begin
            step();
        end
        check({tag, " send_done one cycle"}, send_done, 1'b0);
    endtask

    initial begin
        int err;
        logic [8*NB-1:0] pa;

        rst  = 1'b1;
        send = 1'b0;
        data = '0;
        repeat (3) step();
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset send_done", send_done, 1'b0);
        rst = 1'b0;
        repeat (2) step();
        check("idle tx", tx, 1'b1);

        // single pulse, data = 1
        data = 320'h1;
        send = 1'b1;
        step();
        send = 1'b0;
        check("s1 start tx", tx, 1'b0);
        check("s1 start busy", busy, 1'b1);
        run_frame("s1", 320'h1, 0, -1, '0);
        repeat (5) step();

        // send held high, byte k = k
        data = pat(1, 0);
        send = 1'b1;
        step();
        check("s2 start tx", tx, 1'b0);
        run_frame("s2", pat(1, 0), 0, -1, '0);
        err = 0;
        repeat (60) begin
            if (tx !== 1'b1 || busy !== 1'b0 || send_done !== 1'b0) err++;
            step();
        end
        check("s2 no retrigger while held", err, 0);
        send = 1'b0;
        repeat (3) step();

        // second pulse + data change mid-frame is ignored
        pa = pat(3, 8'h5A);
        data = pa;
        send = 1'b1;
        step();
        send = 1'b0;
        check("s3 start tx", tx, 1'b0);
        run_frame("s3", pa, 1, 500, ~pa);
        err = 0;
        repeat (20) begin
            if (send_done !== 1'b0 || busy !== 1'b0) err++;
            step();
        end
        check("s3 single send_done", err, 0);

        // reset mid-frame
        data = pat(5, 1);
        send = 1'b1;
        step();
        send = 1'b0;
        repeat (300) step();
        check("s4 busy before reset", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s4 tx after reset", tx, 1'b1);
        check("s4 busy after reset", busy, 1'b0);
        err = 0;
        repeat (100) begin
            if (send_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) err++;
            step();
        end
        check("s4 quiet after abort", err, 0);
        data = pat(11, 200);
        send = 1'b1;
        step();
        send = 1'b0;
        check("s4 restart tx", tx, 1'b0);
        run_frame("s4", pat(11, 200), 0, -1, '0);
        repeat (4) step();

        // start event coincident with send_done
        data = pat(7, 3);
        send = 1'b1;
        step();
        check("s5 start tx", tx, 1'b0);
        run_frame("s5a", pat(7, 3), 2, -1, pat(13, 77));
        run_frame("s5b", pat(13, 77), 0, -1, '0);
        send = 1'b0;
        repeat (3) step();

        // send high during reset: frame starts on first edge after release
        rst  = 1'b1;
        send = 1'b1;
        data = pat(17, 9);
        repeat (2) step();
        check("s6 tx in reset", tx, 1'b1);
        rst = 1'b0;
        step();
        check("s6 start tx", tx, 1'b0);
        check("s6 start busy", busy, 1'b1);
        send = 1'b0;
        run_frame("s6", pat(17, 9), 0, -1, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have parameter NUM_BYTES, default 40, bytes per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port send  input  1  transfer request from the frame producer.
REQ-006 SHALL have port data  input  8*NUM_BYTES (320 by default)  frame payload.
REQ-007 SHALL have port send_done  output  1  one-cycle pulse when the frame's last stop bit completes.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1 format, idle high.

Function
REQ-010 SHALL register send each cycle as send_q; a start event is send=1 and send_q=0.
REQ-011 SHALL, on a start event in IDLE, latch data into an internal frame register, set busy=1 and enter START on the next edge.
REQ-012 SHALL ignore start events while busy=1; a data change during a transfer does not affect the frame in flight.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; IDLE->START on start event; START->DATA; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->IDLE.
REQ-014 SHALL drive tx=0 in START, the current data bit in DATA, and tx=1 in STOP and IDLE; tx SHALL be registered.
REQ-015 SHALL hold every bit, including start and stop bits, for exactly CLKS_PER_BIT cycles, using a baud counter cleared on each state entry.
REQ-016 SHALL send byte 0 = data[7:0] first and byte NUM_BYTES-1 last, each byte LSB first.
REQ-017 SHALL insert no idle time between consecutive bytes; the stop bit of byte k is followed directly by the start bit of byte k+1.
REQ-018 SHALL use a byte counter of width ceil(log2(NUM_BYTES)); it SHALL NOT wrap mid-frame.
REQ-019 SHALL take exactly NUM_BYTES*10*CLKS_PER_BIT cycles from the first tx=0 cycle to the end of the last stop bit.
REQ-020 SHALL assert send_done for exactly one cycle, the cycle after the final stop-bit cycle, in the same cycle that busy returns to 0 and the FSM is in IDLE.
REQ-021 SHALL, when send is held high continuously, not start a second frame after send_done; a new frame requires send to go low and then high again.
REQ-022 SHALL, when the cycle carrying send_done also carries a start event, accept that start event; the next frame begins on the following edge.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force state=IDLE, tx=1, busy=0, send_done=0, send_q=0, and clear the baud and byte counters.
REQ-024 SHALL, on reset mid-frame, abort the transfer immediately with tx=1 on the next edge and no send_done pulse.
REQ-025 SHALL treat send=1 on the first edge after reset release as a start event, because send_q=0.

Verification (CLKS_PER_BIT=4, NUM_BYTES=40)
REQ-026 Scenario: data=320'h1, single send pulse -> tx low 4 cycles; byte 0 bits 1,0,0,0,0,0,0,0; stop; 39 bytes of 0x00; send_done one pulse 1600 cycles after the first tx low; busy=0 in the same cycle.
REQ-027 Scenario: data byte k = k (0..39), send held high through completion -> UART decoder receives 0x00..0x27 in order; no second frame after send_done.
REQ-028 Scenario: second send pulse and data change at cycle 500 of a frame -> ignored; decoded bytes match the originally latched data; exactly one send_done.
REQ-029 Scenario: rst=1 for 1 cycle at cycle 300 of a frame -> tx=1 and busy=0 the next cycle; no send_done; a new send pulse then produces a full, correct frame.
REQ-030 Scenario: send toggled low then high so the start event coincides with the send_done cycle -> next frame's start bit begins one cycle later; no idle bits inserted.
REQ-031 Scenario: send=1 while rst=1, then rst released -> frame starts on the first edge after release.
